// File: rtl/ad9361_txrx_seq_pkg.sv
// Shared state codes and default guard times for the AD9361 TX/RX pin sequencer.
package ad9361_txrx_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SW    = 3'd1,
    ST_EN    = 3'd2,
    ST_ON    = 3'd3,
    ST_PAOFF = 3'd4,
    ST_ENOFF = 3'd5
  } seq_state_e;

  localparam int DEF_CNT_W = 16;
  localparam int DEF_T_SW  = 64;
  localparam int DEF_T_PA  = 32;
  localparam int DEF_T_OFF = 16;

  // Counter preload for a wait of max(t,1) cycles: the state exits when the count reaches 0.
  function automatic int guard_load(input int t);
    return (t <= 1) ? 0 : t - 1;
  endfunction

endpackage

// File: rtl/ad9361_txrx_seq_timer.sv
// Guard-time down-counter: load on state entry, count down to zero, then hold.
module ad9361_txrx_seq_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  assign done = (cnt == '0);

  // Reload takes priority; otherwise decrement and saturate at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= load_val;
    else if (!done) cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/ad9361_txrx_seq.sv
// AD9361 TX/RX pin sequencer: orders RF switch, TXNRX, ENABLE and PA enable
// with guard times, and ramps fully down before any direction change.
module ad9361_txrx_seq
  import ad9361_txrx_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int T_SW  = DEF_T_SW,
  parameter int T_PA  = DEF_T_PA,
  parameter int T_OFF = DEF_T_OFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_req,
  input  logic       tx_req,
  output logic       rf_sw,
  output logic       txnrx,
  output logic       enable,
  output logic       pa_en,
  output logic       busy,
  output logic [2:0] state
);

  localparam logic [CNT_W-1:0] LD_SW  = CNT_W'(guard_load(T_SW));
  localparam logic [CNT_W-1:0] LD_PA  = CNT_W'(guard_load(T_PA));
  localparam logic [CNT_W-1:0] LD_OFF = CNT_W'(guard_load(T_OFF));

  seq_state_e       state_q, state_n;
  logic             dir_q, dir_n;
  logic             rf_sw_n, txnrx_n, enable_n, pa_en_n, busy_n;
  logic             tmr_load, tmr_done, abort;
  logic [CNT_W-1:0] tmr_val;

  ad9361_txrx_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign state = state_q;

  // Next state, next pin levels and timer preload for the state being entered.
  always_comb begin
    state_n  = state_q;
    dir_n    = dir_q;
    rf_sw_n  = rf_sw;
    txnrx_n  = txnrx;
    enable_n = enable;
    pa_en_n  = pa_en;
    tmr_load = 1'b0;
    tmr_val  = '0;
    abort    = !run_req || (tx_req != dir_q);
    case (state_q)
      ST_IDLE: if (run_req) begin
        // Direction pins only move here, with ENABLE and PA guaranteed low.
        state_n  = ST_SW;
        dir_n    = tx_req;
        rf_sw_n  = tx_req;
        txnrx_n  = tx_req;
        tmr_load = 1'b1;
        tmr_val  = LD_SW;
      end
      ST_SW, ST_EN: begin
        if (abort) begin
          state_n  = ST_PAOFF;
          pa_en_n  = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = dir_q ? LD_PA : '0;
        end else if (state_q == ST_SW) begin
          if (tmr_done) begin
            state_n  = ST_EN;
            enable_n = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = LD_PA;
          end
        end else if (!dir_q) begin
          state_n = ST_ON;
        end else if (tmr_done) begin
          state_n = ST_ON;
          pa_en_n = 1'b1;
        end
      end
      ST_ON: if (abort) begin
        state_n  = ST_PAOFF;
        pa_en_n  = 1'b0;
        tmr_load = 1'b1;
        tmr_val  = dir_q ? LD_PA : '0;
      end
      ST_PAOFF: if (tmr_done) begin
        state_n  = ST_ENOFF;
        enable_n = 1'b0;
        tmr_load = 1'b1;
        tmr_val  = LD_OFF;
      end
      ST_ENOFF: if (tmr_done) state_n = ST_IDLE;
      default: begin
        // Unused codes: drop the radio pins and restart from IDLE.
        state_n  = ST_IDLE;
        enable_n = 1'b0;
        pa_en_n  = 1'b0;
      end
    endcase
    busy_n = !((state_n == ST_IDLE) || (state_n == ST_ON));
  end

  // State, direction latch and all output pins are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      rf_sw   <= 1'b0;
      txnrx   <= 1'b0;
      enable  <= 1'b0;
      pa_en   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_n;
      dir_q   <= dir_n;
      rf_sw   <= rf_sw_n;
      txnrx   <= txnrx_n;
      enable  <= enable_n;
      pa_en   <= pa_en_n;
      busy    <= busy_n;
    end
  end

endmodule

// File: tb/tb_ad9361_txrx_seq.sv
// Directed bench for ad9361_txrx_seq with T_SW=4, T_PA=8, T_OFF=2, plus a random-toggle invariant soak.
module tb_ad9361_txrx_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run_req = 1'b0;
  logic       tx_req = 1'b0;
  logic       rf_sw, txnrx, enable, pa_en, busy;
  logic [2:0] state;

  int nvec = 0;
  int nerr = 0;
  bit mon_en = 1'b0;
  logic rf_sw_p = 1'b0, txnrx_p = 1'b0, enable_p = 1'b0, pa_en_p = 1'b0;

  ad9361_txrx_seq #(.CNT_W(16), .T_SW(4), .T_PA(8), .T_OFF(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .run_req (run_req),
    .tx_req  (tx_req),
    .rf_sw   (rf_sw),
    .txnrx   (txnrx),
    .enable  (enable),
    .pa_en   (pa_en),
    .busy    (busy),
    .state   (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pin-ordering invariants, sampled every cycle away from the active edge.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (txnrx != txnrx_p) chk("txnrx_moved_with_en", {enable_p, enable}, 2'b00);
      if (rf_sw != rf_sw_p) chk("rfsw_moved_with_pa", {pa_en_p, pa_en}, 2'b00);
      chk("pa_implies_en", pa_en & ~enable, 1'b0);
      chk("pa_implies_tx", pa_en & ~txnrx, 1'b0);
    end
    rf_sw_p  <= rf_sw;
    txnrx_p  <= txnrx;
    enable_p <= enable;
    pa_en_p  <= pa_en;
  end

  initial begin
    // Reset state
    step(3);
    chk("reset_pins", {rf_sw, txnrx, enable, pa_en, busy, state}, 8'h00);
    rst = 1'b0;
    step(1);
    chk("post_reset_idle", {busy, state}, 4'h0);
    mon_en = 1'b1;

    // 1: RX ramp-up
    run_req = 1'b1; tx_req = 1'b0;
    step(1);
    chk("rx_k_state", state, 3'd1);
    chk("rx_k_pins", {rf_sw, txnrx, enable, busy}, 4'b0001);
    step(3);
    chk("rx_k3_enable", enable, 1'b0);
    step(1);
    chk("rx_k4_enable", {enable, state}, {1'b1, 3'd2});
    step(1);
    chk("rx_k5_on", {state, busy, pa_en}, {3'd3, 1'b0, 1'b0});

    // RX ramp-down to IDLE
    run_req = 1'b0;
    step(1);
    chk("rxoff_paoff", {state, enable}, {3'd4, 1'b1});
    step(1);
    chk("rxoff_enoff", {state, enable}, {3'd5, 1'b0});
    step(2);
    chk("rxoff_idle", {state, busy, rf_sw}, {3'd0, 1'b0, 1'b0});

    // 2: TX ramp-up
    run_req = 1'b1; tx_req = 1'b1;
    step(1);
    chk("tx_k_pins", {rf_sw, txnrx, enable, pa_en, busy, state}, {4'b1100, 1'b1, 3'd1});
    step(3);
    chk("tx_k3_enable", enable, 1'b0);
    step(1);
    chk("tx_k4", {enable, pa_en, busy, state}, {3'b101, 3'd2});
    step(7);
    chk("tx_k11", {pa_en, busy}, 2'b01);
    step(1);
    chk("tx_k12", {pa_en, busy, state}, {2'b10, 3'd3});

    // 3: TX -> RX direction change
    tx_req = 1'b0;
    step(1);
    chk("dir_paoff", {pa_en, enable, state}, {2'b01, 3'd4});
    step(7);
    chk("dir_j7_enable", enable, 1'b1);
    step(1);
    chk("dir_j8", {enable, txnrx, state}, {2'b01, 3'd5});
    step(2);
    chk("dir_j10_idle", {state, txnrx, rf_sw}, {3'd0, 2'b11});
    step(1);
    chk("dir_j11_sw", {state, txnrx, rf_sw, enable}, {3'd1, 3'b000});
    step(4);
    chk("dir_rx_enable", enable, 1'b1);
    step(1);
    chk("dir_rx_on", {state, pa_en}, {3'd3, 1'b0});

    // 4: abort 2 cycles into SW
    run_req = 1'b0;
    step(4);
    chk("ab_pre_idle", state, 3'd0);
    run_req = 1'b1;
    step(1);
    chk("ab_k_sw", state, 3'd1);
    step(1);
    run_req = 1'b0;
    step(1);
    chk("ab_paoff", {state, enable}, {3'd4, 1'b0});
    step(1);
    chk("ab_enoff", {state, enable}, {3'd5, 1'b0});
    step(1);
    chk("ab_enoff2", {state, enable, busy}, {3'd5, 2'b01});
    step(1);
    chk("ab_idle", {state, enable, busy}, {3'd0, 2'b00});

    // 5: reset during TX ON
    run_req = 1'b1; tx_req = 1'b1;
    step(13);
    chk("rst_pre_on", {state, pa_en, enable}, {3'd3, 2'b11});
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1 chk("rst_async", {rf_sw, txnrx, enable, pa_en, busy, state}, 8'h00);
    step(2);
    rst = 1'b0;
    step(1);
    chk("rst_restart", {state, rf_sw, txnrx, enable}, {3'd1, 3'b110});
    step(2);
    mon_en = 1'b1;

    // 6: random request toggling; invariants checked by the monitor
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) run_req = 1'($urandom);
      if ($urandom_range(0, 23) == 0) tx_req  = 1'($urandom);
    end
    run_req = 1'b0;
    step(20);
    chk("soak_idle", {state, enable, pa_en}, {3'd0, 2'b00});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
